// File: rtl/pr_timer_pkg.sv
// Shared definitions for the pr_timer block: register offsets, CTRL bit
// positions, FSM state encodings and MODE encodings.
package pr_timer_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_t;

    // Assemble the CTRL read value; unused bits read as zero
    function automatic logic [31:0] ctrl_word(logic en, mode_t mode, logic im);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT] = en;
        w[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        w[CTRL_IM_BIT] = im;
        return w;
    endfunction

endpackage

// File: rtl/pr_timer_if.sv
// Bus-side interface of pr_timer: bridge write strobe, address, data and
// the interrupt request line.
interface pr_timer_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output we, addr, wdata,
        input  rdata, irq
    );

    modport slave (
        input  we, addr, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/pr_timer.sv
// pr_timer: programmable down-counting timer with CTRL/PRESET/COUNT
// registers and a level interrupt. Optional auto-reload (MODE=1) is
// compiled in only when PR_TIMER_MODE1_EN is defined; otherwise the MODE
// field is not stored, reads 0 and every run is one-shot.
module pr_timer
    import pr_timer_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    pr_timer_if.slave bus
);

    state_t      state;
    logic [31:0] preset;
    logic [31:0] count;
    logic        ctrl_en;
    logic        ctrl_im;
    logic        irq_flag;
    mode_t       mode_rd;
    logic        reload;
    logic [1:0]  reg_sel;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_addr_bits;

    assign reg_sel   = bus.addr[3:2];
    assign ctrl_wr   = bus.we && (reg_sel == REG_CTRL);
    assign preset_wr = bus.we && (reg_sel == REG_PRESET);
    assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef PR_TIMER_MODE1_EN
    mode_t ctrl_mode;
    assign mode_rd = ctrl_mode;
    // MODE 2/3 fall back to one-shot behaviour
    assign reload  = (ctrl_mode == MODE_RELOAD);
`else
    assign mode_rd = MODE_ONESHOT;
    assign reload  = 1'b0;
`endif

    // PRESET register: CPU-written, consumed only when the FSM is in LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= '0;
        end else if (preset_wr) begin
            preset <= bus.wdata;
        end
    end

    // CTRL register and counter FSM share EN/irq_flag, so they live together.
    // A CPU CTRL write is applied first; later FSM assignments override it,
    // except the INT-exit EN clear, which yields to a concurrent CTRL write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            ctrl_en  <= 1'b0;
            ctrl_im  <= 1'b0;
            irq_flag <= 1'b0;
`ifdef PR_TIMER_MODE1_EN
            ctrl_mode <= MODE_ONESHOT;
`endif
        end else begin
            if (ctrl_wr) begin
                ctrl_en  <= bus.wdata[CTRL_EN_BIT];
                ctrl_im  <= bus.wdata[CTRL_IM_BIT];
                irq_flag <= 1'b0;
`ifdef PR_TIMER_MODE1_EN
                ctrl_mode <= mode_t'(bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
`endif
            end

            unique case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count <= 32'd1) begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                ST_INT: begin
                    state <= ST_IDLE;
                    if (reload) begin
                        irq_flag <= 1'b0;
                    end else if (!ctrl_wr) begin
                        ctrl_en <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Combinational read mux
    always_comb begin
        bus.rdata = '0;
        case (reg_sel)
            REG_CTRL:   bus.rdata = ctrl_word(ctrl_en, mode_rd, ctrl_im);
            REG_PRESET: bus.rdata = preset;
            REG_COUNT:  bus.rdata = count;
            default:    bus.rdata = '0;
        endcase
    end

    assign bus.irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_pr_timer.sv
// Scoreboard bench for pr_timer: the driver pushes expected read/irq values
// and pulses sample_req; the monitor pops and compares against the DUT.
module tb_pr_timer;
    import pr_timer_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          is_irq;
    } item_t;

    logic   clk;
    logic   reset;
    logic   sample_req;
    item_t  sb[$];
    item_t  mon_it;
    logic [31:0] mon_act;
    int     compared = 0;
    int     mismatched = 0;

    pr_timer_if bus();

    pr_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor: compare each sampled DUT output against the queued expectation
    always @(posedge sample_req) begin
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_empty: sample without expectation");
        end else begin
            mon_it  = sb.pop_front();
            mon_act = mon_it.is_irq ? {31'd0, bus.irq} : bus.rdata;
            compared++;
            if (mon_act !== mon_it.exp) begin
                mismatched++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", mon_it.name, mon_act, mon_it.exp);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = {28'd0, off, 2'b00};
        bus.wdata = d;
        step(1);
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic push_and_sample(input string n, input logic [31:0] e, input bit is_irq);
        item_t it;
        it.name   = n;
        it.exp    = e;
        it.is_irq = is_irq;
        sb.push_back(it);
        sample_req = 1'b1;
        #1;
        sample_req = 1'b0;
    endtask

    task automatic ck(input string n, input logic [1:0] off, input logic [31:0] e);
        bus.addr = {28'd0, off, 2'b00};
        #1;
        push_and_sample(n, e, 1'b0);
    endtask

    task automatic ci(input string n, input logic e);
        #1;
        push_and_sample(n, {31'd0, e}, 1'b1);
    endtask

    initial begin
        reset      = 1'b0;
        sample_req = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        #3;
        ck("rst_ctrl",   REG_CTRL,   32'd0);
        ck("rst_preset", REG_PRESET, 32'd0);
        ck("rst_count",  REG_COUNT,  32'd0);
        ci("rst_irq", 1'b0);
        step(2);
        reset = 1'b1;
        step(1);

        // One-shot: PRESET=5, irq 6 cycles after LOAD, held, EN cleared
        wr(REG_PRESET, 32'd5);
        wr(REG_CTRL, 32'h9);
        step(6);
        ck("a_count_one", REG_COUNT, 32'd1);
        ci("a_irq_low", 1'b0);
        step(1);
        ci("a_irq_rise", 1'b1);
        ck("a_count_zero", REG_COUNT, 32'd0);
        step(1);
        ck("a_en_cleared", REG_CTRL, 32'h8);
        ci("a_irq_hold", 1'b1);
        step(3);
        ci("a_irq_hold_late", 1'b1);

        // CTRL write clears irq_flag; timer stays idle
        wr(REG_CTRL, 32'h8);
        ci("b_irq_fall", 1'b0);
        ck("b_ctrl", REG_CTRL, 32'h8);
        step(4);
        ci("b_irq_idle", 1'b0);
        ck("b_count_idle", REG_COUNT, 32'd0);

`ifdef PR_TIMER_MODE1_EN
        // Auto-reload: 1-cycle irq pulse every 6 cycles
        wr(REG_PRESET, 32'd3);
        wr(REG_CTRL, 32'hB);
        ck("c_ctrl_mode1", REG_CTRL, 32'hB);
        step(4);
        for (int k = 0; k < 3; k++) begin
            ci($sformatf("c_irq_pre%0d", k), 1'b0);
            step(1);
            ci($sformatf("c_irq_pulse%0d", k), 1'b1);
            step(1);
            ci($sformatf("c_irq_drop%0d", k), 1'b0);
            step(4);
        end
        step(1);
        ci("c_irq_last", 1'b1);
        wr(REG_CTRL, 32'h8);
        ci("c_irq_off", 1'b0);
        step(3);
        ci("c_irq_stopped", 1'b0);
        ck("c_ctrl_off", REG_CTRL, 32'h8);
`else
        // MODE bits not stored: MODE=1 request behaves as one-shot
        wr(REG_PRESET, 32'd3);
        wr(REG_CTRL, 32'hB);
        ck("c_ctrl_nomode", REG_CTRL, 32'h9);
        step(5);
        ci("c_irq_rise", 1'b1);
        step(1);
        ci("c_irq_hold", 1'b1);
        ck("c_en_cleared", REG_CTRL, 32'h8);
        step(6);
        ci("c_irq_hold_late", 1'b1);
        wr(REG_CTRL, 32'h8);
        ci("c_irq_off", 1'b0);
`endif

        // MODE=2 behaves as one-shot
        wr(REG_PRESET, 32'd1);
        wr(REG_CTRL, 32'hD);
        step(3);
        ci("m2_irq", 1'b1);
        step(1);
`ifdef PR_TIMER_MODE1_EN
        ck("m2_en_cleared", REG_CTRL, 32'hC);
`else
        ck("m2_en_cleared", REG_CTRL, 32'h8);
`endif
        ci("m2_irq_hold", 1'b1);
        step(3);
        ci("m2_irq_hold_late", 1'b1);
        wr(REG_CTRL, 32'h8);
        ci("m2_irq_off", 1'b0);

        // CTRL write in the INT cycle keeps the written EN
        wr(REG_PRESET, 32'd2);
        wr(REG_CTRL, 32'h9);
        step(4);
        ci("race_irq", 1'b1);
        wr(REG_CTRL, 32'h9);
        ck("race_en_kept", REG_CTRL, 32'h9);
        ci("race_irq_clr", 1'b0);
        step(4);
        ci("race_rerun_irq", 1'b1);
        step(1);
        ck("race_en_clr", REG_CTRL, 32'h8);
        wr(REG_CTRL, 32'h8);

        // PRESET=0 behaves as PRESET=1
        wr(REG_PRESET, 32'd0);
        wr(REG_CTRL, 32'h9);
        step(2);
        ci("p0_irq_before", 1'b0);
        ck("p0_count", REG_COUNT, 32'd0);
        step(1);
        ci("p0_irq_rise", 1'b1);
        wr(REG_CTRL, 32'h8);
        ci("p0_irq_off", 1'b0);

        // PRESET write during CNT, EN clear freezes COUNT, re-enable with new PRESET
        wr(REG_PRESET, 32'd100);
        wr(REG_CTRL, 32'h9);
        step(29);
        ck("d_count_73", REG_COUNT, 32'd73);
        wr(REG_PRESET, 32'd7);
        ck("d_count_kept", REG_COUNT, 32'd72);
        ck("d_preset_new", REG_PRESET, 32'd7);
        step(31);
        ck("d_count_41", REG_COUNT, 32'd41);
        wr(REG_CTRL, 32'h8);
        ck("d_frozen", REG_COUNT, 32'd40);
        step(5);
        ck("d_frozen_late", REG_COUNT, 32'd40);
        ci("d_irq_none", 1'b0);
        wr(REG_CTRL, 32'h9);
        step(7);
        ck("d_count_2", REG_COUNT, 32'd2);
        ci("d_irq_pre", 1'b0);
        step(1);
        ck("d_count_1", REG_COUNT, 32'd1);
        ci("d_irq_pre2", 1'b0);
        step(1);
        ci("d_irq_rise", 1'b1);
        ck("d_count_0", REG_COUNT, 32'd0);
        wr(REG_CTRL, 32'h8);

        // Read-only COUNT and reserved offset ignore writes
        wr(REG_PRESET, 32'd10);
        wr(REG_CTRL, 32'h8);
        wr(REG_COUNT, 32'h1234);
        wr(REG_RSVD, 32'hFFFF_FFFF);
        ck("e_count_ro", REG_COUNT, 32'd0);
        ck("e_rsvd", REG_RSVD, 32'd0);
        ck("e_preset", REG_PRESET, 32'd10);
        ck("e_ctrl", REG_CTRL, 32'h8);

        // Asynchronous reset mid-count
        wr(REG_PRESET, 32'd5);
        wr(REG_CTRL, 32'h9);
        step(5);
        ck("f_count_2", REG_COUNT, 32'd2);
        reset = 1'b0;
        ck("f_ctrl_rst", REG_CTRL, 32'd0);
        ck("f_preset_rst", REG_PRESET, 32'd0);
        ck("f_count_rst", REG_COUNT, 32'd0);
        ci("f_irq_rst", 1'b0);
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            ci($sformatf("f_irq_quiet%0d", i), 1'b0);
        end
        ck("f_ctrl_after", REG_CTRL, 32'd0);
        ck("f_count_after", REG_COUNT, 32'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
